// File: rtl/washer_pkg.sv
// Shared definitions for the washing-machine cycle sequencer.
// Holds the FSM state encoding, the two-bit phase codes presented on the
// phase output, the default prescaler length, and small helpers that pick
// the next non-empty phase and that phase's duration.
package washer_pkg;

    localparam int TICKS_PER_UNIT_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WASH  = 3'd1,
        ST_RINSE = 3'd2,
        ST_SPIN  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] PHASE_IDLE  = 2'b00;
    localparam logic [1:0] PHASE_WASH  = 2'b01;
    localparam logic [1:0] PHASE_RINSE = 2'b10;
    localparam logic [1:0] PHASE_SPIN  = 2'b11;

    function automatic logic is_phase(state_e st);
        return (st == ST_WASH) || (st == ST_RINSE) || (st == ST_SPIN);
    endfunction

    // First phase after 'cur' (in wash, rinse, spin order) whose duration is
    // nonzero; DONE when every later phase is empty. Empty phases are never
    // entered, so no cycle is spent in them.
    function automatic state_e next_phase(state_e cur, logic [3:0] w, logic [3:0] r, logic [3:0] s);
        state_e nxt;
        nxt = ST_DONE;
        if (cur == ST_IDLE && w != 4'd0) begin
            nxt = ST_WASH;
        end else if ((cur == ST_IDLE || cur == ST_WASH) && r != 4'd0) begin
            nxt = ST_RINSE;
        end else if ((cur == ST_IDLE || cur == ST_WASH || cur == ST_RINSE) && s != 4'd0) begin
            nxt = ST_SPIN;
        end
        return nxt;
    endfunction

    function automatic logic [3:0] phase_duration(state_e st, logic [3:0] w, logic [3:0] r, logic [3:0] s);
        logic [3:0] d;
        case (st)
            ST_WASH:  d = w;
            ST_RINSE: d = r;
            ST_SPIN:  d = s;
            default:  d = 4'd0;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] phase_code(state_e st);
        logic [1:0] c;
        case (st)
            ST_WASH:  c = PHASE_WASH;
            ST_RINSE: c = PHASE_RINSE;
            ST_SPIN:  c = PHASE_SPIN;
            default:  c = PHASE_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cycle_sequencer_if.sv
// Bundle of the sequencer's control inputs and status/actuator outputs.
//   master : drives cycle_ready, durations, door_closed, pause, abort;
//            observes phase, actuators, door_lock, remaining_units, busy,
//            cycle_done.
//   slave  : the sequencer side (directions reversed).
interface cycle_sequencer_if;

    logic       cycle_ready;
    logic [3:0] wash_duration;
    logic [3:0] rinse_duration;
    logic [3:0] spin_duration;
    logic       door_closed;
    logic       pause;
    logic       abort;

    logic [1:0] phase;
    logic       wash_motor;
    logic       water_valve;
    logic       spin_motor;
    logic       door_lock;
    logic [3:0] remaining_units;
    logic       busy;
    logic       cycle_done;

    modport master (
        output cycle_ready, wash_duration, rinse_duration, spin_duration,
               door_closed, pause, abort,
        input  phase, wash_motor, water_valve, spin_motor, door_lock,
               remaining_units, busy, cycle_done
    );

    modport slave (
        input  cycle_ready, wash_duration, rinse_duration, spin_duration,
               door_closed, pause, abort,
        output phase, wash_motor, water_valve, spin_motor, door_lock,
               remaining_units, busy, cycle_done
    );

endinterface

// File: rtl/cycle_sequencer_phase_timer.sv
// Phase timer: a prescaler counting 0..TICKS_PER_UNIT-1 feeding a 4-bit
// unit down-counter.
//   clk, reset     : clock, synchronous active-high reset
//   clear_i        : zero both counters (cycle cancelled)
//   load_i         : phase entry; value <= load_value_i, prescaler <= 0
//   en_i           : a phase is running
//   hold_i         : freeze both counters
//   value_o        : units left in the current phase
//   expire_o       : last tick of the last unit; phase ends at this edge
module phase_timer
    import washer_pkg::*;
#(
    parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [3:0] load_value_i,
    input  logic       en_i,
    input  logic       hold_i,
    output logic [3:0] value_o,
    output logic       expire_o
);

    localparam logic [15:0] PRESC_MAX = 16'(TICKS_PER_UNIT - 1);

    logic [15:0] presc_q;
    logic [3:0]  value_q;
    logic        count_en;
    logic        wrap;

    assign count_en = en_i && !hold_i;
    assign wrap     = (presc_q == PRESC_MAX);
    assign expire_o = count_en && wrap && (value_q == 4'd1);
    assign value_o  = value_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            presc_q <= '0;
            value_q <= '0;
        end else if (load_i) begin
            presc_q <= '0;
            value_q <= load_value_i;
        end else if (count_en) begin
            if (wrap) begin
                presc_q <= '0;
                // Final unit drops to 0 so remaining_units reads 0 in DONE.
                if (value_q != 4'd0) begin
                    value_q <= value_q - 4'd1;
                end
            end else begin
                presc_q <= presc_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// Washing-machine cycle sequencer: IDLE -> WASH -> RINSE -> SPIN -> DONE,
// skipping zero-length phases, with pause/door hold and abort.
//   clk, reset : clock, synchronous active-high reset
//   bus        : cycle_sequencer_if.slave -- cycle_ready, three 4-bit
//                durations, door_closed, pause, abort in; phase, actuator
//                enables, door_lock, remaining_units, busy, cycle_done out.
// Every output comes straight from a register.
module cycle_sequencer
    import washer_pkg::*;
#(
    parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    cycle_sequencer_if.slave    bus
);

    state_e     state_q, state_d;
    logic       latch_durations;
    logic       tmr_load;
    logic       tmr_clear;
    logic [3:0] tmr_load_value;
    logic [3:0] tmr_value;
    logic       tmr_expire;
    logic       hold;

    logic [3:0] dur_in [3];
    logic [3:0] dur_q  [3];
    logic [3:0] dur_src [3];

    logic [1:0] phase_q;
    logic       wash_motor_q;
    logic       water_valve_q;
    logic       spin_motor_q;
    logic       busy_q;
    logic       cycle_done_q;

    assign hold = bus.pause || !bus.door_closed;

    assign dur_in[0] = bus.wash_duration;
    assign dur_in[1] = bus.rinse_duration;
    assign dur_in[2] = bus.spin_duration;

    // Durations are latched once per cycle, only when a start is accepted.
    // While starting, the phase choice must use the live inputs because
    // the latch has not happened yet.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dur
            always_ff @(posedge clk) begin
                if (reset) begin
                    dur_q[gi] <= '0;
                end else if (latch_durations) begin
                    dur_q[gi] <= dur_in[gi];
                end
            end
            assign dur_src[gi] = (state_q == ST_IDLE) ? dur_in[gi] : dur_q[gi];
        end
    endgenerate

    phase_timer #(
        .TICKS_PER_UNIT (TICKS_PER_UNIT)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (tmr_clear),
        .load_i       (tmr_load),
        .load_value_i (tmr_load_value),
        .en_i         (is_phase(state_q)),
        .hold_i       (hold),
        .value_o      (tmr_value),
        .expire_o     (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        latch_durations = 1'b0;
        tmr_clear       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cycle_ready && bus.door_closed && !bus.abort) begin
                    latch_durations = 1'b1;
                    state_d = next_phase(ST_IDLE, dur_src[0], dur_src[1], dur_src[2]);
                end
            end
            ST_WASH, ST_RINSE, ST_SPIN: begin
                // Abort beats completion; expire is already gated by hold.
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    tmr_clear = 1'b1;
                end else if (tmr_expire) begin
                    state_d = next_phase(state_q, dur_src[0], dur_src[1], dur_src[2]);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        tmr_load       = (state_d != state_q) && is_phase(state_d);
        tmr_load_value = phase_duration(state_d, dur_src[0], dur_src[1], dur_src[2]);
    end

    // Outputs are computed from the next state so they line up with the
    // state register; actuators also see this cycle's hold, giving one
    // cycle of latency from pause/door to the enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= PHASE_IDLE;
            wash_motor_q  <= 1'b0;
            water_valve_q <= 1'b0;
            spin_motor_q  <= 1'b0;
            busy_q        <= 1'b0;
            cycle_done_q  <= 1'b0;
        end else begin
            phase_q       <= phase_code(state_d);
            wash_motor_q  <= (state_d == ST_WASH)  && !hold;
            water_valve_q <= (state_d == ST_RINSE) && !hold;
            spin_motor_q  <= (state_d == ST_SPIN)  && !hold;
            busy_q        <= (state_d != ST_IDLE);
            cycle_done_q  <= (state_d == ST_DONE);
        end
    end

    assign bus.phase           = phase_q;
    assign bus.wash_motor      = wash_motor_q;
    assign bus.water_valve     = water_valve_q;
    assign bus.spin_motor      = spin_motor_q;
    assign bus.door_lock       = busy_q;
    assign bus.busy            = busy_q;
    assign bus.remaining_units = tmr_value;
    assign bus.cycle_done      = cycle_done_q;

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have parameter TICKS_PER_UNIT, default 4, clk cycles per duration unit (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cycle_ready  input  1  one-cycle pulse; durations valid this cycle.
REQ-005 SHALL have ports wash_duration, rinse_duration, spin_duration  input  4 each  phase lengths in units.
REQ-006 SHALL have port door_closed  input  1  high = door shut.
REQ-007 SHALL have port pause  input  1  level; high holds the running phase.
REQ-008 SHALL have port abort  input  1  level; high cancels the cycle.
REQ-009 SHALL have port phase  output  2  00 idle, 01 wash, 10 rinse, 11 spin.
REQ-010 SHALL have ports wash_motor, water_valve, spin_motor  output  1 each  actuator enables.
REQ-011 SHALL have port door_lock  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port remaining_units  output  4  units left in the current phase; 0 when idle.
REQ-013 SHALL have port busy  output  1  high in WASH, RINSE, SPIN or DONE.
REQ-014 SHALL have port cycle_done  output  1  one-cycle pulse on normal completion.

Function
REQ-015 SHALL implement states IDLE, WASH, RINSE, SPIN, DONE; all outputs are registered.
REQ-016 In IDLE, cycle_ready=1 with door_closed=1 and abort=0 SHALL latch all three durations and, next cycle, enter the first phase (order wash, rinse, spin) with nonzero duration, else DONE.
REQ-017 cycle_ready while not IDLE, or with door_closed=0, SHALL be ignored; durations are not re-latched.
REQ-018 On phase entry, remaining_units SHALL load the phase duration and the prescaler SHALL clear to 0.
REQ-019 While running, prescaler SHALL count 0..TICKS_PER_UNIT-1; on wrap, remaining_units SHALL decrement by 1.
REQ-020 When remaining_units=1 and prescaler wraps, the next cycle SHALL enter the next nonzero-duration phase, or DONE; a phase of duration D therefore lasts exactly D*TICKS_PER_UNIT unpaused cycles.
REQ-021 Zero-duration phases SHALL be skipped with no cycle spent in them.
REQ-022 Hold condition = pause=1 or door_closed=0; while held, prescaler, remaining_units and state SHALL freeze and all actuator outputs SHALL be 0.
REQ-023 When not held: wash_motor=1 in WASH, water_valve=1 in RINSE, spin_motor=1 in SPIN; otherwise 0.
REQ-024 DONE SHALL last exactly one cycle, assert cycle_done for that cycle, then return to IDLE.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE next cycle with cycle_done=0; abort has priority over completion, pause and cycle_ready.
REQ-026 Hold and phase-end in the same cycle: hold wins; phase does not advance.
REQ-027 Actuator outputs SHALL reflect the registered state and hold condition with one cycle latency from inputs.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE, prescaler 0, latched durations 0, and every output 0, including mid-phase; it overrides all other inputs.

Structure
REQ-029 State encoding, phase codes (00..11) and the TICKS_PER_UNIT default SHALL live in shared package washer_pkg.
REQ-030 Prescaler plus unit down-counter SHALL be one sub-module, phase_timer (load, hold, value, expire outputs).

Verification (TICKS_PER_UNIT=2)
REQ-031 Durations 3/2/1, door closed, no pause -> WASH 6 cycles, RINSE 4, SPIN 2, then one cycle_done pulse, then IDLE.
REQ-032 Durations 0/2/0 -> IDLE goes directly to RINSE for 4 cycles, then DONE; durations 0/0/0 -> DONE the cycle after cycle_ready.
REQ-033 WASH with remaining_units=2, pause held for 5 cycles -> outputs 0, counters frozen; on release, WASH completes its remaining 4 cycles.
REQ-034 door_closed=0 during RINSE -> water_valve 0 and hold; cycle_ready while door open in IDLE -> no start.
REQ-035 abort in SPIN -> IDLE next cycle, cycle_done never asserts; reset mid-WASH -> all outputs 0 next cycle.
REQ-036 Second cycle_ready pulse during WASH with different durations -> ignored; original timing unchanged.
